// File: rtl/flash_boot_loader_pkg.sv
// Shared constants and state encoding for the flash-to-SRAM boot copy.
// Base/size constants are also used by the top-level bus mux.
package flash_boot_loader_pkg;

    typedef enum logic [3:0] {
        ST_CMD_SETUP = 4'd0,
        ST_CMD_WE    = 4'd1,
        ST_CMD_HOLD  = 4'd2,
        ST_RD_LO     = 4'd3,
        ST_RD_HI     = 4'd4,
        ST_SR_SETUP  = 4'd5,
        ST_SR_WE     = 4'd6,
        ST_SR_HOLD   = 4'd7,
        ST_DONE      = 4'd8
    } boot_state_e;

    localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

    localparam logic [22:0] BOOT_FLASH_BASE  = 23'h000000;
    localparam logic [19:0] BOOT_SRAM_BASE   = 20'h00000;
    localparam int          BOOT_WORD_COUNT  = 1024;
    localparam int          BOOT_WAIT_CYCLES = 4;

    // Bits needed to hold 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flash_boot_loader.sv
// Boot copy engine: puts flash in read-array mode, copies WORD_COUNT
// 32-bit words (two 16-bit reads each) into SRAM, then releases the CPU.
// Ports: clk/rst (sync, active-high); flash* = flash pad bus;
// sram* = base SRAM pad bus; pauseRequest_o stalls the pipeline;
// bootDone_o marks the image resident and hands the buses to the CPU.
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter int          WORD_COUNT  = BOOT_WORD_COUNT,
    parameter logic [22:0] FLASH_BASE  = BOOT_FLASH_BASE,
    parameter logic [19:0] SRAM_BASE   = BOOT_SRAM_BASE,
    parameter int          WAIT_CYCLES = BOOT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    output logic [22:0] flashAddr_o,
    input  logic [15:0] flashData_i,
    output logic [15:0] flashData_o,
    output logic        flashDataOutEn_o,
    output logic        flashCE_n_o,
    output logic        flashOE_n_o,
    output logic        flashWE_n_o,
    output logic [19:0] sramAddr_o,
    output logic [31:0] sramData_o,
    output logic        sramDataOutEn_o,
    output logic        sramCE_n_o,
    output logic        sramOE_n_o,
    output logic        sramWE_n_o,
    output logic [3:0]  sramBE_n_o,
    output logic        pauseRequest_o,
    output logic        bootDone_o
);

    localparam int CW = cnt_width(WORD_COUNT);
    localparam int WW = cnt_width(WAIT_CYCLES);

    localparam logic [CW-1:0] LAST_K = CW'(WORD_COUNT - 1);
    localparam logic [WW-1:0] LAST_W = WW'(WAIT_CYCLES - 1);

    boot_state_e   state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [15:0]   lo_q, lo_d;
    logic [15:0]   hi_q, hi_d;

    logic [22:0]   rd_addr;
    logic [19:0]   wr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CMD_SETUP;
            k_q     <= '0;
            wait_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wait_d  = wait_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            ST_CMD_SETUP: state_d = ST_CMD_WE;
            ST_CMD_WE:    state_d = ST_CMD_HOLD;
            ST_CMD_HOLD: begin
                wait_d  = '0;
                state_d = (WORD_COUNT == 0) ? ST_DONE
                                            : ST_RD_LO;
            end
            ST_RD_LO: begin
                if (wait_q == LAST_W) begin
                    lo_d    = flashData_i;
                    wait_d  = '0;
                    state_d = ST_RD_HI;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RD_HI: begin
                if (wait_q == LAST_W) begin
                    hi_d    = flashData_i;
                    wait_d  = '0;
                    state_d = ST_SR_SETUP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SR_SETUP: state_d = ST_SR_WE;
            ST_SR_WE:    state_d = ST_SR_HOLD;
            ST_SR_HOLD: begin
                k_d     = k_q + 1'b1;
                state_d = (k_q == LAST_K) ? ST_DONE
                                          : ST_RD_LO;
            end
            ST_DONE:     state_d = ST_DONE;
            default:     state_d = ST_CMD_SETUP;
        endcase
    end

    // Both address generators wrap at their bus width.
    always_comb begin
        rd_addr = FLASH_BASE + (23'(k_q) << 2);
        if (state_q == ST_RD_HI) begin
            rd_addr = rd_addr + 23'd2;
        end
        wr_addr = SRAM_BASE + 20'(k_q);
    end

    // Outputs decode registered state only; rst forces the idle
    // bus in every cycle it is held.
    always_comb begin
        flashAddr_o      = FLASH_BASE;
        flashData_o      = '0;
        flashDataOutEn_o = 1'b0;
        flashCE_n_o      = 1'b1;
        flashOE_n_o      = 1'b1;
        flashWE_n_o      = 1'b1;
        sramAddr_o       = SRAM_BASE;
        sramData_o       = '0;
        sramDataOutEn_o  = 1'b0;
        sramCE_n_o       = 1'b1;
        sramOE_n_o       = 1'b1;
        sramWE_n_o       = 1'b1;
        sramBE_n_o       = 4'hF;
        pauseRequest_o   = 1'b1;
        bootDone_o       = 1'b0;
        if (!rst) begin
            flashAddr_o = {rd_addr[22:1], 1'b0};
            sramAddr_o  = wr_addr;
            unique case (state_q)
                ST_CMD_SETUP,
                ST_CMD_WE,
                ST_CMD_HOLD: begin
                    flashCE_n_o      = 1'b0;
                    flashData_o      = FLASH_CMD_READ_ARRAY;
                    flashDataOutEn_o = 1'b1;
                    flashWE_n_o      = (state_q != ST_CMD_WE);
                end
                ST_RD_LO,
                ST_RD_HI: begin
                    flashCE_n_o = 1'b0;
                    flashOE_n_o = 1'b0;
                end
                ST_SR_SETUP,
                ST_SR_WE,
                ST_SR_HOLD: begin
                    sramData_o      = {hi_q, lo_q};
                    sramDataOutEn_o = 1'b1;
                    sramCE_n_o      = 1'b0;
                    sramBE_n_o      = 4'h0;
                    sramWE_n_o      = (state_q != ST_SR_WE);
                end
                ST_DONE: begin
                    pauseRequest_o = 1'b0;
                    bootDone_o     = 1'b1;
                end
                default: begin
                    pauseRequest_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader: four instances with
// different parameters, flash/SRAM models and bus monitors.
module tb_flash_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        rst2 = 1'b1, rst3 = 1'b1;

    logic [22:0] fa0, fa1, fa2, fa3;
    logic [15:0] fdi0, fdi1, fdi2, fdi3;
    logic [15:0] fdo0, fdo1, fdo2, fdo3;
    logic        foe0, foe1, foe2, foe3;
    logic        fce0, fce1, fce2, fce3;
    logic        foen0, foen1, foen2, foen3;
    logic        fwe0, fwe1, fwe2, fwe3;
    logic [19:0] sa0, sa1, sa2, sa3;
    logic [31:0] sd0, sd1, sd2, sd3;
    logic        soe0, soe1, soe2, soe3;
    logic        sce0, sce1, sce2, sce3;
    logic        soen0, soen1, soen2, soen3;
    logic        swe0, swe1, swe2, swe3;
    logic [3:0]  sbe0, sbe1, sbe2, sbe3;
    logic        pr0, pr1, pr2, pr3;
    logic        bd0, bd1, bd2, bd3;

    function automatic logic [15:0] fm_tab(input logic [22:0] a);
        case (a[2:1])
            2'd0:    return 16'h1111;
            2'd1:    return 16'h2222;
            2'd2:    return 16'h3333;
            default: return 16'h4444;
        endcase
    endfunction

    function automatic logic [15:0] fm_xor(input logic [22:0] a);
        return a[16:1] ^ 16'h5A5A;
    endfunction

    assign fdi0 = (!foen0 && !fce0) ? fm_tab(fa0) : 16'hDEAD;
    assign fdi1 = (!foen1 && !fce1) ? fm_tab(fa1) : 16'hDEAD;
    assign fdi2 = (!foen2 && !fce2) ? fm_tab(fa2) : 16'hDEAD;
    assign fdi3 = (!foen3 && !fce3) ? fm_xor(fa3) : 16'hDEAD;

    flash_boot_loader #(
        .WORD_COUNT(2), .FLASH_BASE(23'h0),
        .SRAM_BASE(20'h0), .WAIT_CYCLES(4)
    ) u0 (
        .clk(clk), .rst(rst0),
        .flashAddr_o(fa0), .flashData_i(fdi0),
        .flashData_o(fdo0), .flashDataOutEn_o(foe0),
        .flashCE_n_o(fce0), .flashOE_n_o(foen0),
        .flashWE_n_o(fwe0), .sramAddr_o(sa0),
        .sramData_o(sd0), .sramDataOutEn_o(soe0),
        .sramCE_n_o(sce0), .sramOE_n_o(soen0),
        .sramWE_n_o(swe0), .sramBE_n_o(sbe0),
        .pauseRequest_o(pr0), .bootDone_o(bd0)
    );

    flash_boot_loader #(
        .WORD_COUNT(0), .FLASH_BASE(23'h0),
        .SRAM_BASE(20'h0), .WAIT_CYCLES(4)
    ) u1 (
        .clk(clk), .rst(rst1),
        .flashAddr_o(fa1), .flashData_i(fdi1),
        .flashData_o(fdo1), .flashDataOutEn_o(foe1),
        .flashCE_n_o(fce1), .flashOE_n_o(foen1),
        .flashWE_n_o(fwe1), .sramAddr_o(sa1),
        .sramData_o(sd1), .sramDataOutEn_o(soe1),
        .sramCE_n_o(sce1), .sramOE_n_o(soen1),
        .sramWE_n_o(swe1), .sramBE_n_o(sbe1),
        .pauseRequest_o(pr1), .bootDone_o(bd1)
    );

    flash_boot_loader #(
        .WORD_COUNT(2), .FLASH_BASE(23'h0),
        .SRAM_BASE(20'h0), .WAIT_CYCLES(1)
    ) u2 (
        .clk(clk), .rst(rst2),
        .flashAddr_o(fa2), .flashData_i(fdi2),
        .flashData_o(fdo2), .flashDataOutEn_o(foe2),
        .flashCE_n_o(fce2), .flashOE_n_o(foen2),
        .flashWE_n_o(fwe2), .sramAddr_o(sa2),
        .sramData_o(sd2), .sramDataOutEn_o(soe2),
        .sramCE_n_o(sce2), .sramOE_n_o(soen2),
        .sramWE_n_o(swe2), .sramBE_n_o(sbe2),
        .pauseRequest_o(pr2), .bootDone_o(bd2)
    );

    flash_boot_loader #(
        .WORD_COUNT(16), .FLASH_BASE(23'h7FFFF8),
        .SRAM_BASE(20'h0), .WAIT_CYCLES(2)
    ) u3 (
        .clk(clk), .rst(rst3),
        .flashAddr_o(fa3), .flashData_i(fdi3),
        .flashData_o(fdo3), .flashDataOutEn_o(foe3),
        .flashCE_n_o(fce3), .flashOE_n_o(foen3),
        .flashWE_n_o(fwe3), .sramAddr_o(sa3),
        .sramData_o(sd3), .sramDataOutEn_o(soe3),
        .sramCE_n_o(sce3), .sramOE_n_o(soen3),
        .sramWE_n_o(swe3), .sramBE_n_o(sbe3),
        .pauseRequest_o(pr3), .bootDone_o(bd3)
    );

    logic [31:0] sm0 [0:31];
    logic [31:0] sm1 [0:31];
    logic [31:0] sm2 [0:31];
    logic [31:0] sm3 [0:31];
    int wec0 = 0, wec1 = 0, wec2 = 0, wec3 = 0;

    always @(posedge clk) begin
        if (!sce0 && !swe0) begin
            sm0[sa0[4:0]] <= sd0;
            wec0 <= wec0 + 1;
        end
        if (!sce1 && !swe1) begin
            sm1[sa1[4:0]] <= sd1;
            wec1 <= wec1 + 1;
        end
        if (!sce2 && !swe2) begin
            sm2[sa2[4:0]] <= sd2;
            wec2 <= wec2 + 1;
        end
        if (!sce3 && !swe3) begin
            sm3[sa3[4:0]] <= sd3;
            wec3 <= wec3 + 1;
        end
    end

    // Address/data stability around every WE_n=0 cycle on u0.
    logic [19:0] p_sa  = '0;
    logic [31:0] p_sd  = '0;
    logic        p_swe = 1'b1;
    logic [22:0] p_fa  = '0;
    logic [15:0] p_fdo = '0;
    logic        p_fwe = 1'b1;
    int stab_viol = 0;

    always @(posedge clk) begin
        if ((!swe0 || !p_swe) &&
            (sa0 !== p_sa || sd0 !== p_sd))
            stab_viol <= stab_viol + 1;
        else if ((!fwe0 || !p_fwe) &&
            (fa0 !== p_fa || fdo0 !== p_fdo))
            stab_viol <= stab_viol + 1;
        p_sa  <= sa0;
        p_sd  <= sd0;
        p_swe <= swe0;
        p_fa  <= fa0;
        p_fdo <= fdo0;
        p_fwe <= fwe0;
    end

    // Turnaround, odd address and wrap monitor on u3.
    int turn_viol = 0, odd_addr = 0;
    int wrap_seen = 0, wrap_bad = 0;
    logic [22:0] last_rd3 = '0;

    always @(posedge clk) begin
        if (!rst3) begin
            if ((foe3 && !foen3) || (soe3 && !soen3))
                turn_viol <= turn_viol + 1;
            if (fa3[0])
                odd_addr <= odd_addr + 1;
            if (!foen3) begin
                if (last_rd3 == 23'h7FFFFE &&
                    fa3 != 23'h7FFFFE) begin
                    wrap_seen <= wrap_seen + 1;
                    if (fa3 != 23'h0)
                        wrap_bad <= wrap_bad + 1;
                end
                last_rd3 <= fa3;
            end
        end
    end

    task automatic test_reset;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        vec++;
        if ({fce0, foen0, fwe0, sce0, soen0, swe0} !== 6'h3F) begin
            errs++;
            $display("FAIL reset_strobes got %b want 111111",
                     {fce0, foen0, fwe0, sce0, soen0, swe0});
        end
        vec++;
        if (sbe0 !== 4'hF) begin
            errs++;
            $display("FAIL reset_be got %h want f", sbe0);
        end
        vec++;
        if ({foe0, soe0} !== 2'b00) begin
            errs++;
            $display("FAIL reset_oen got %b want 00", {foe0, soe0});
        end
        vec++;
        if (fdo0 !== 16'h0 || sd0 !== 32'h0) begin
            errs++;
            $display("FAIL reset_data got %h/%h want 0/0", fdo0, sd0);
        end
        vec++;
        if (fa0 !== 23'h0 || sa0 !== 20'h0) begin
            errs++;
            $display("FAIL reset_addr got %h/%h want 0/0", fa0, sa0);
        end
        vec++;
        if ({pr0, bd0} !== 2'b10) begin
            errs++;
            $display("FAIL reset_pause_done got %b want 10",
                     {pr0, bd0});
        end
    endtask

    task automatic test_copy;
        int done_c;
        logic pr_at;
        logic [18:0] exp_cmd;
        done_c = -1;
        pr_at  = 1'b1;
        @(posedge clk);
        #1 rst0 = 1'b0;
        for (int c = 0; c < 60 && done_c < 0; c++) begin
            @(negedge clk);
            if (c < 3) begin
                exp_cmd = {16'h00FF, 1'b1, 1'b1, (c != 1)};
                vec++;
                if ({fdo0, foe0, foen0, fwe0} !== exp_cmd) begin
                    errs++;
                    $display("FAIL cmd_cycle%0d got %h want %h", c,
                             {fdo0, foe0, foen0, fwe0}, exp_cmd);
                end
            end
            if (bd0 === 1'b1) begin
                done_c = c;
                pr_at  = pr0;
            end
        end
        vec++;
        if (done_c !== 25) begin
            errs++;
            $display("FAIL copy_done_cycle got %0d want 25", done_c);
        end
        vec++;
        if (pr_at !== 1'b0) begin
            errs++;
            $display("FAIL copy_pause got %b want 0", pr_at);
        end
        vec++;
        if (sm0[0] !== 32'h22221111) begin
            errs++;
            $display("FAIL copy_word0 got %h want 22221111", sm0[0]);
        end
        vec++;
        if (sm0[1] !== 32'h44443333) begin
            errs++;
            $display("FAIL copy_word1 got %h want 44443333", sm0[1]);
        end
        vec++;
        if (wec0 !== 2) begin
            errs++;
            $display("FAIL copy_we_count got %0d want 2", wec0);
        end
    endtask

    task automatic test_reset_mid;
        int base_w, done_c;
        done_c = -1;
        #1 rst0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst0 = 1'b0;
        base_w = wec0;
        repeat (14) @(posedge clk);
        #1 rst0 = 1'b1;
        vec++;
        if (wec0 - base_w !== 1) begin
            errs++;
            $display("FAIL mid_pre_writes got %0d want 1",
                     wec0 - base_w);
        end
        for (int c = 15; c <= 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            vec++;
            if ({fce0, foen0, fwe0, sce0, swe0, foe0, soe0,
                 pr0, bd0} !== 9'b111110010) begin
                errs++;
                $display("FAIL mid_reset_cycle%0d got %b want %b", c,
                         {fce0, foen0, fwe0, sce0, swe0, foe0, soe0,
                          pr0, bd0}, 9'b111110010);
            end
        end
        @(posedge clk);
        #1 rst0 = 1'b0;
        base_w = wec0;
        for (int c = 0; c < 60 && done_c < 0; c++) begin
            @(negedge clk);
            if (bd0 === 1'b1) done_c = c;
        end
        vec++;
        if (done_c !== 25) begin
            errs++;
            $display("FAIL mid_done_cycle got %0d want 25", done_c);
        end
        vec++;
        if (wec0 - base_w !== 2 || sm0[0] !== 32'h22221111 ||
            sm0[1] !== 32'h44443333) begin
            errs++;
            $display("FAIL mid_contents got %0d %h %h want 2 %h %h",
                     wec0 - base_w, sm0[0], sm0[1],
                     32'h22221111, 32'h44443333);
        end
        vec++;
        if (stab_viol !== 0) begin
            errs++;
            $display("FAIL we_stability got %0d want 0", stab_viol);
        end
    endtask

    task automatic test_zero;
        int done_c;
        logic pr_at;
        done_c = -1;
        pr_at  = 1'b1;
        @(posedge clk);
        #1 rst1 = 1'b0;
        for (int c = 0; c < 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (bd1 === 1'b1) begin
                done_c = c;
                pr_at  = pr1;
            end
        end
        repeat (3) @(posedge clk);
        vec++;
        if (done_c !== 3 || pr_at !== 1'b0) begin
            errs++;
            $display("FAIL zero_done got %0d/%b want 3/0",
                     done_c, pr_at);
        end
        vec++;
        if (wec1 !== 0) begin
            errs++;
            $display("FAIL zero_we_count got %0d want 0", wec1);
        end
    endtask

    task automatic test_wait1;
        int done_c;
        done_c = -1;
        @(posedge clk);
        #1 rst2 = 1'b0;
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            @(negedge clk);
            if (bd2 === 1'b1) done_c = c;
        end
        vec++;
        if (done_c !== 13) begin
            errs++;
            $display("FAIL wait1_done got %0d want 13", done_c);
        end
        vec++;
        if (sm2[0] !== 32'h22221111 || sm2[1] !== 32'h44443333) begin
            errs++;
            $display("FAIL wait1_words got %h %h want %h %h",
                     sm2[0], sm2[1], 32'h22221111, 32'h44443333);
        end
    endtask

    task automatic test_wrap;
        int done_c;
        done_c = -1;
        @(posedge clk);
        #1 rst3 = 1'b0;
        for (int c = 0; c < 300 && done_c < 0; c++) begin
            @(negedge clk);
            if (bd3 === 1'b1) done_c = c;
        end
        vec++;
        if (done_c !== 115) begin
            errs++;
            $display("FAIL wrap_done got %0d want 115", done_c);
        end
        vec++;
        if (turn_viol !== 0 || odd_addr !== 0) begin
            errs++;
            $display("FAIL wrap_bus got %0d/%0d want 0/0",
                     turn_viol, odd_addr);
        end
        vec++;
        if (wrap_seen !== 1 || wrap_bad !== 0) begin
            errs++;
            $display("FAIL wrap_addr got %0d/%0d want 1/0",
                     wrap_seen, wrap_bad);
        end
        vec++;
        if (sm3[0] !== 32'hA5A7A5A6 || sm3[1] !== 32'hA5A5A5A4) begin
            errs++;
            $display("FAIL wrap_pre got %h %h want %h %h",
                     sm3[0], sm3[1], 32'hA5A7A5A6, 32'hA5A5A5A4);
        end
        vec++;
        if (sm3[2] !== 32'h5A5B5A5A || sm3[3] !== 32'h5A595A58) begin
            errs++;
            $display("FAIL wrap_post got %h %h want %h %h",
                     sm3[2], sm3[3], 32'h5A5B5A5A, 32'h5A595A58);
        end
        vec++;
        if (wec3 !== 16) begin
            errs++;
            $display("FAIL wrap_we_count got %0d want 16", wec3);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_reset_mid();
        test_zero();
        test_wait1();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, errs);
        $finish;
    end

endmodule
